// File: rtl/cpu_defs.sv
// Shared fetch-path constants and the response record carried by the instruction-memory responder.
package cpu_defs;
    localparam int INST_W       = 32;
    localparam int ADDR_W       = 32;
    localparam int IMEM_LAT_MAX = 4;
    localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0000;

    typedef struct packed {
        logic              err;
        logic [ADDR_W-1:0] addr;
        logic [INST_W-1:0] inst;
    } imem_ent_t;

    // A fetch is bad when it is not word aligned or falls beyond the ROM.
    function automatic logic fetch_bad(input logic [ADDR_W-1:0] addr, input int depth_log2);
        return (addr[1:0] != 2'b00) || ((addr >> (depth_log2 + 2)) != '0);
    endfunction
endpackage

// File: rtl/imem_resp_if.sv
// Fetch request / instruction response bundle between the PC/decode side (master) and imem_resp (slave).
interface imem_resp_if;
    import cpu_defs::*;

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              flush;
    logic              resp_valid;
    logic              resp_ready;
    logic [INST_W-1:0] resp_inst;
    logic [ADDR_W-1:0] resp_addr;
    logic              resp_err;
    logic              busy;

    modport master (
        output req_valid, req_addr, flush, resp_ready,
        input  req_ready, resp_valid, resp_inst, resp_addr, resp_err, busy
    );

    modport slave (
        input  req_valid, req_addr, flush, resp_ready,
        output req_ready, resp_valid, resp_inst, resp_addr, resp_err, busy
    );
endinterface

// File: rtl/imem_fifo.sv
// Synchronous first-word-fall-through FIFO; an empty FIFO shows a same-cycle push at its head.
// Backpressure: no internal stall, the producer must never push into a full FIFO without a pop.
module imem_fifo #(
    parameter int DEPTH = 3,
    parameter int W     = 65
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stored_empty, wr_en, rd_en;

    assign stored_empty = (cnt_q == '0);
    assign empty        = stored_empty && !push;
    assign full         = (cnt_q == CNT_FULL);
    assign head_dat     = stored_empty ? push_dat : mem_q[rd_ptr_q];
    // A word pushed and popped in the same cycle while empty never touches storage.
    assign wr_en        = push && !(stored_empty && pop);
    assign rd_en        = pop && !stored_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (wr_en) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clear) mem_q[wr_ptr_q] <= push_dat;
    end
endmodule

// File: rtl/imem_resp.sv
// Instruction ROM responder: returns {inst, addr, err} LATENCY cycles after accept, one word per cycle.
// Backpressure: responses queue in a LATENCY+1 FIFO; req_ready drops at LATENCY+1 outstanding fetches.
module imem_resp
    import cpu_defs::*;
#(
    parameter int    DEPTH_LOG2 = 10,
    parameter int    LATENCY    = 2,
    parameter string INIT_FILE  = "imem.hex"
) (
    input  logic        clk,
    input  logic        rest_n,
    imem_resp_if.slave  bus
);
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int FIFO_DEPTH = LATENCY + 1;
    localparam logic [2:0] OUTST_MAX = 3'(LATENCY + 1);
    localparam bit HAS_IMAGE = (INIT_FILE != "");

    // Contents are placed by the image loader through hierarchy; this block only reads them.
    logic [INST_W-1:0] rom [DEPTH];

    logic [2:0]            outst_q, outst_d;
    logic [LATENCY-1:0]    stg_vld_q, stg_vld_d;
    imem_ent_t             stg_q [LATENCY];
    imem_ent_t             stg_d [LATENCY];
    imem_ent_t             req_ent, head_ent;
    logic                  req_acc, resp_hs, fifo_full, fifo_empty, req_bad;
    logic [DEPTH_LOG2-1:0] word_idx;

    assign word_idx = bus.req_addr[DEPTH_LOG2+1:2];
    assign req_bad  = fetch_bad(bus.req_addr, DEPTH_LOG2);

    always_comb begin
        req_ent      = '0;
        req_ent.err  = req_bad;
        req_ent.addr = bus.req_addr;
        req_ent.inst = (req_bad || !HAS_IMAGE) ? INST_NOP : rom[word_idx];
    end

    assign bus.req_ready  = !bus.flush && (outst_q < OUTST_MAX);
    assign req_acc        = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = !fifo_empty && !bus.flush;
    assign resp_hs        = bus.resp_valid && bus.resp_ready;
    assign bus.resp_inst  = head_ent.inst;
    assign bus.resp_addr  = head_ent.addr;
    assign bus.resp_err   = head_ent.err;
    assign bus.busy       = (outst_q != '0);

    always_comb begin
        outst_d   = outst_q;
        stg_vld_d = stg_vld_q;
        stg_d     = stg_q;
        if (bus.flush) begin
            outst_d   = '0;
            stg_vld_d = '0;
        end else begin
            case ({req_acc, resp_hs})
                2'b10:   outst_d = outst_q + 3'd1;
                2'b01:   outst_d = outst_q - 3'd1;
                default: outst_d = outst_q;
            endcase
            stg_vld_d[0] = req_acc;
            if (req_acc) stg_d[0] = req_ent;
            // Stages never stall: the outstanding limit guarantees FIFO room for every word in flight.
            for (int k = 1; k < LATENCY; k++) begin
                stg_vld_d[k] = stg_vld_q[k-1];
                if (stg_vld_q[k-1]) stg_d[k] = stg_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rest_n) begin
            outst_q   <= '0;
            stg_vld_q <= '0;
            for (int k = 0; k < LATENCY; k++) stg_q[k] <= '0;
        end else begin
            outst_q   <= outst_d;
            stg_vld_q <= stg_vld_d;
            stg_q     <= stg_d;
        end
    end

    imem_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(imem_ent_t))
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rest_n),
        .clear    (bus.flush),
        .push     (stg_vld_q[LATENCY-1]),
        .push_dat (stg_q[LATENCY-1]),
        .pop      (resp_hs),
        .head_dat (head_ent),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rest_n)
        !(stg_vld_q[LATENCY-1] && fifo_full && !resp_hs && !bus.flush));
    a_latency_legal: assert property (@(posedge clk)
        (LATENCY >= 1) && (LATENCY <= IMEM_LAT_MAX));
endmodule

// File: tb/tb_imem_resp.sv
// Bench for imem_resp: directed scenarios plus random traffic, scored against an in-order queue model.
module tb_imem_resp;
    import cpu_defs::*;

    localparam int LAT = 2;
    localparam int DL2 = 10;

    logic clk    = 1'b0;
    logic rest_n = 1'b0;

    imem_resp_if bus();

    imem_resp #(.DEPTH_LOG2(DL2), .LATENCY(LAT), .INIT_FILE("imem.hex")) dut (
        .clk    (clk),
        .rest_n (rest_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          errors   = 0;
    int          edge_cnt = 0;
    logic [67:0] obs_vec, exp_vec;
    logic        obs_vld, obs_rdy, obs_busy, obs_err;
    logic [31:0] obs_inst, obs_addr;
    logic        last_acc, last_hs;

    // Expected fetch result from the address alone; visible from edge 'due' onward.
    function automatic exp_t ref_fetch(input logic [31:0] a, input int due);
        exp_t e;
        e.addr = a;
        e.due  = due;
        e.err  = (a[1:0] != 2'b00) || ((a >> (DL2 + 2)) != 0);
        e.inst = e.err ? 32'h0 : 32'h1000_0000 + (a >> 2);
        return e;
    endfunction

    // One clock: snapshot DUT and model prediction at negedge, then advance the model at posedge.
    task automatic tick();
        logic m_rdy, m_vld, m_acc;
        exp_t h;
        @(negedge clk);
        m_rdy = !bus.flush && (q.size() < LAT + 1);
        m_vld = 1'b0;
        h.inst = 32'h0; h.addr = 32'h0; h.err = 1'b0; h.due = 0;
        if (q.size() > 0) begin
            h = q[0];
            m_vld = !bus.flush && (h.due <= edge_cnt);
        end
        obs_rdy  = bus.req_ready;
        obs_vld  = bus.resp_valid;
        obs_busy = bus.busy;
        obs_inst = bus.resp_inst;
        obs_addr = bus.resp_addr;
        obs_err  = bus.resp_err;
        last_acc = bus.req_valid && obs_rdy;
        last_hs  = obs_vld && bus.resp_ready;
        exp_vec  = {m_rdy, m_vld, q.size() != 0, m_vld ? {h.err, h.addr, h.inst} : 65'b0};
        obs_vec  = {obs_rdy, obs_vld, obs_busy, obs_vld ? {obs_err, obs_addr, obs_inst} : 65'b0};
        m_acc    = bus.req_valid && m_rdy;
        @(posedge clk);
        edge_cnt++;
        if (!rest_n || bus.flush) begin
            q.delete();
        end else begin
            if (m_vld && bus.resp_ready) void'(q.pop_front());
            if (m_acc) q.push_back(ref_fetch(bus.req_addr, edge_cnt + LAT - 1));
        end
        #1;
    endtask

    task automatic test_reset();
        rest_n = 1'b0;
        repeat (3) tick();
        rest_n = 1'b1;
        checks++;
        if ({bus.resp_valid, bus.resp_inst, bus.resp_addr, bus.resp_err, bus.busy, bus.req_ready}
            !== {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: vld=%b inst=%h addr=%h err=%b busy=%b rdy=%b, need 0 0 0 0 0 1",
                     bus.resp_valid, bus.resp_inst, bus.resp_addr, bus.resp_err, bus.busy, bus.req_ready);
        end
    endtask

    task automatic test_stream();
        int n = 0;
        int acc_edge = -1;
        int vld_edge = -1;
        logic [31:0] got[$];
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bus.req_valid = (n < 4);
            bus.req_addr  = 32'(n * 4);
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL stream c%0d: got %h need %h", c, obs_vec, exp_vec);
            end
            if (last_acc) begin
                if (n == 0) acc_edge = edge_cnt;
                n++;
            end
            if (last_hs) begin
                if (got.size() == 0) vld_edge = edge_cnt - 1;
                got.push_back(obs_inst);
            end
        end
        bus.req_valid = 1'b0;
        checks++;
        if (vld_edge - acc_edge !== LAT - 1) begin
            errors++;
            $display("FAIL stream_latency: first valid %0d edges after accept, need %0d", vld_edge - acc_edge, LAT - 1);
        end
        checks++;
        if (got.size() !== 4) begin
            errors++;
            $display("FAIL stream_count: got %0d responses, need 4", got.size());
        end
        for (int k = 0; k < got.size(); k++) begin
            checks++;
            if (got[k] !== 32'h1000_0000 + 32'(k)) begin
                errors++;
                $display("FAIL stream_inst%0d: got %h need %h", k, got[k], 32'h1000_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic [31:0] got[$];
        bus.resp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            bus.req_valid = (n < 4);
            bus.req_addr  = 32'(n * 4);
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL bp_hold c%0d: got %h need %h", c, obs_vec, exp_vec);
            end
            if (obs_vld) begin
                checks++;
                if (obs_inst !== 32'h1000_0000) begin
                    errors++;
                    $display("FAIL bp_stable c%0d: resp_inst %h need 10000000", c, obs_inst);
                end
            end
            if (last_acc) n++;
        end
        checks++;
        if (n !== 3 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_limit: accepts=%0d req_ready=%b, need 3 and 0", n, bus.req_ready);
        end
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = (n < 4);
            bus.req_addr  = 32'(n * 4);
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL bp_drain c%0d: got %h need %h", c, obs_vec, exp_vec);
            end
            if (last_acc) n++;
            if (last_hs) got.push_back(obs_inst);
        end
        bus.req_valid = 1'b0;
        checks++;
        if (got.size() !== 4) begin
            errors++;
            $display("FAIL bp_count: got %0d responses, need 4", got.size());
        end
        for (int k = 0; k < got.size(); k++) begin
            checks++;
            if (got[k] !== 32'h1000_0000 + 32'(k)) begin
                errors++;
                $display("FAIL bp_order%0d: got %h need %h", k, got[k], 32'h1000_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [2];
        logic [64:0] got[$];
        int n = 0;
        addrs[0] = 32'h0000_0006;
        addrs[1] = 32'h0000_1000;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.req_valid = (n < 2);
            bus.req_addr  = addrs[n < 2 ? n : 1];
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL err_seq c%0d: got %h need %h", c, obs_vec, exp_vec);
            end
            if (last_acc) n++;
            if (last_hs) got.push_back({obs_err, obs_addr, obs_inst});
        end
        bus.req_valid = 1'b0;
        checks++;
        if (got.size() !== 2) begin
            errors++;
            $display("FAIL err_count: got %0d responses, need 2", got.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got[k] !== {1'b1, addrs[k], 32'h0}) begin
                    errors++;
                    $display("FAIL err_resp%0d: got %h need %h", k, got[k], {1'b1, addrs[k], 32'h0});
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] got[$];
        bus.resp_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 32'(n * 4);
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL flush_issue n%0d: got %h need %h", n, obs_vec, exp_vec);
            end
        end
        bus.req_valid = 1'b0;
        bus.flush     = 1'b1;
        tick();
        checks++;
        if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL flush_cycle: got %h need %h", obs_vec, exp_vec);
        end
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_after: busy=%b resp_valid=%b, need 0 0", bus.busy, bus.resp_valid);
        end
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h50;
        for (int c = 0; c < 6; c++) begin
            tick();
            bus.req_valid = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL flush_post c%0d: got %h need %h", c, obs_vec, exp_vec);
            end
            if (last_hs) got.push_back(obs_inst);
        end
        checks++;
        if (got.size() !== 1 || got[0] !== 32'h1000_0014) begin
            errors++;
            $display("FAIL flush_next: got %0d responses first %h, need 1 of 10000014",
                     got.size(), got.size() > 0 ? got[0] : 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got[$];
        bus.resp_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 32'(n * 4 + 32);
            tick();
        end
        bus.req_valid = 1'b0;
        rest_n = 1'b0;
        tick();
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: resp_valid=%b busy=%b, need 0 0", bus.resp_valid, bus.busy);
        end
        rest_n = 1'b1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready: req_ready=%b need 1", bus.req_ready);
        end
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h0;
        for (int c = 0; c < 5; c++) begin
            tick();
            bus.req_valid = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL rstmid_post c%0d: got %h need %h", c, obs_vec, exp_vec);
            end
            if (last_hs) got.push_back(obs_inst);
        end
        checks++;
        if (got.size() !== 1 || got[0] !== 32'h1000_0000) begin
            errors++;
            $display("FAIL rstmid_fetch: got %0d responses first %h, need 1 of 10000000",
                     got.size(), got.size() > 0 ? got[0] : 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < LAT + 20; c++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 32'(n * 4 + 256);
            tick();
            if (last_acc) n++;
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL b2b_model c%0d: got %h need %h", c, obs_vec, exp_vec);
            end
            if (c >= LAT) begin
                checks++;
                if ({last_acc, last_hs, obs_busy} !== 3'b111) begin
                    errors++;
                    $display("FAIL b2b_steady c%0d: acc/hs/busy=%b need 111", c, {last_acc, last_hs, obs_busy});
                end
            end
        end
        bus.req_valid = 1'b0;
        repeat (LAT + 2) tick();
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       bus.req_addr = 32'($urandom_range(0, 1023)) << 2;
            else if (r == 7) bus.req_addr = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
            else if (r == 8) bus.req_addr = 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
            else             bus.req_addr = $urandom;
            bus.req_valid  = ($urandom_range(0, 3) != 0);
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            bus.flush      = ($urandom_range(0, 19) == 0);
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL random c%0d: got %h need %h", c, obs_vec, exp_vec);
            end
        end
        bus.flush      = 1'b0;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < LAT + 6; c++) begin
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL random_drain c%0d: got %h need %h", c, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'h0;
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < (1 << DL2); i++) dut.rom[i] = 32'h1000_0000 + 32'(i);
        test_reset();
        test_stream();
        test_backpressure();
        test_errors();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_resp.md
Name: imem_resp

Overview:
- Instruction-memory responder on the fetch side of the CPU.
- It sits on the other end of the program counter's address output.
- It accepts fetch requests (PC value) over a valid/ready handshake and reads a word-addressed ROM image. It returns the instruction word, tagged with its address, after a fixed pipeline latency.
- It also supports a flush, used when a branch or jump is taken, which discards all in-flight fetches.

Parameters:
- DEPTH_LOG2, 10, log2 of ROM depth in 32-bit words (1024 words).
- LATENCY, 2, read pipeline stages from request accept to earliest response; legal range 1..4.
- INIT_FILE, "imem.hex", hex image loaded into the ROM at elaboration.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rest_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  PC side presents a fetch address.
- req_addr  in  32  byte address of the instruction.
- req_ready  out  1  block can accept a request this cycle.
- flush  in  1  discard all pending and buffered fetches.
- resp_valid  out  1  resp_* fields hold a valid instruction.
- resp_ready  in  1  decode side accepts the response.
- resp_inst  out  32  instruction word.
- resp_addr  out  32  byte address that produced resp_inst.
- resp_err  out  1  misaligned or out-of-range fetch.
- busy  out  1  at least one fetch is outstanding.

Behaviour:
- Reset: when rest_n=0 at a clock edge, the following are cleared:
  - pipeline valids, FIFO pointers and the outstanding counter;
  - resp_valid=0, resp_inst=0, resp_addr=0, resp_err=0, busy=0.
  - ROM contents are kept.
  - Reset mid-operation drops all in-flight fetches silently.
- Accept: a request is accepted when req_valid && req_ready.
- req_ready = !flush && (outstanding < LATENCY+1).
- Outstanding counter (width 3):
  - +1 on accept; -1 on a response handshake (resp_valid && resp_ready).
  - Both in the same cycle: unchanged.
  - busy = (outstanding != 0).
- Pipeline: LATENCY stages, each holding valid, addr, inst and err.
  - Stage 0 captures the ROM read of word index req_addr[DEPTH_LOG2+1:2].
- Error cases (pipeline entry gets inst=INST_NOP (0x00000000) and err=1):
  - misaligned: req_addr[1:0] != 0;
  - out of range: req_addr[31:DEPTH_LOG2+2] != 0.
- Output FIFO:
  - Depth LATENCY+1, first-word-fall-through, fed from the last pipeline stage.
  - resp_* come directly from the FIFO head; resp_valid = !empty && !flush.
  - Because of the outstanding limit, the FIFO can never overflow. An overflow attempt is an assertion failure in simulation.
- Latency: a request accepted at edge N with an empty FIFO gives resp_valid=1 in the cycle after edge N+LATENCY-1. With resp_ready held at 1, throughput is 1 word per cycle.
- Backpressure: with resp_ready=0, resp_* stay stable and the FIFO fills. req_ready drops once LATENCY+1 fetches are outstanding.
- Flush:
  - While flush=1, resp_valid and req_ready are forced to 0, so no handshake occurs that cycle.
  - At that edge, all pipeline valids and the FIFO are cleared and outstanding is set to 0.
  - A request may be accepted the cycle after flush falls.
- Ordering: responses leave in request order; there is no reordering.

Decomposition:
- Shared package, cpu_defs:
  - INST_NOP = 32'h00000000;
  - INST_W = 32 and ADDR_W = 32;
  - an IMEM_LAT_MAX = 4 guard constant.
- Sub-module imem_fifo: a parameterised synchronous FWFT FIFO with push, pop, clear, full, empty and a 65-bit payload (inst, addr, err).
- The ROM array and the pipeline stages stay in imem_resp.

Test Plan:
- Image word i = 0x10000000+i is loaded for every scenario below.
- Reset then stream: reset 3 cycles, then req_valid=1 for addrs 0x0, 0x4, 0x8, 0xC with resp_ready=1.
  -> resp_inst = 0x10000000..0x10000003 in order, first resp_valid 2 cycles after the first accept, one per cycle, resp_err=0.
- Backpressure: resp_ready=0 while issuing 0x0, 0x4, 0x8, 0xC.
  -> req_ready=0 after 3 accepts; resp_inst holds 0x10000000 stable.
  -> Raising resp_ready drains 0x10000000..0x10000003 in order with no loss or duplicate.
- Error fetches: addr 0x6 -> resp_err=1, resp_inst=0, resp_addr=0x6. Addr 0x00001000 -> resp_err=1, resp_inst=0.
- Flush mid-stream: issue 0x0, 0x4, 0x8, assert flush 1 cycle, then issue 0x50.
  -> no response for 0x0/0x4/0x8 after the flush; next response is 0x10000014 at 0x50; busy=0 after the flush edge.
- Reset mid-operation: drive rest_n=0 with 3 fetches outstanding.
  -> next cycle resp_valid=0, busy=0, req_ready=1 after release; a new fetch of 0x0 returns 0x10000000.
- Simultaneous accept and handshake: hold both every cycle for 20 cycles.
  -> outstanding stays constant and busy=1 throughout.
